ext_mux_scan_sequencer: RTL

//  Sequences the external 16:1 analog multiplexer that sits in front of the XADC auxiliary input.

---
 rtl/ext_mux_scan_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ext_mux_scan_sequencer.sv
// Masked round-robin scan of the external 16:1 analog mux ahead of the ADC aux input.
// Optional macro EXT_MUX_TIMEOUT_EN adds a conversion timeout with a sticky timeout_err flag.
module ext_mux_scan_sequencer #(
   parameter int NUM_CH         = 16,
   parameter int SETTLE_CYCLES  = 64,
   parameter int ADC_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [15:0]      ch_mask,
   output logic [3:0]       gpio_sel,
   output logic             adc_convst,
   input  logic             adc_eoc,
   input  logic [ADC_W-1:0] adc_data,
   output logic             smp_valid,
   input  logic             smp_ready,
   output logic [3:0]       smp_ch,
   output logic [ADC_W-1:0] smp_data,
   output logic             scan_done,
   output logic             busy,
   output logic             timeout_err
);

`ifdef EXT_MUX_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int CNT_MAX = (TMO_EN && (TIMEOUT_CYCLES > SETTLE_CYCLES)) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [15:0] VALID_MASK = 16'((32'h1 << NUM_CH) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_SETTLE, S_CONVST, S_WAIT_EOC, S_OUTPUT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         sel_q, sel_d;
   logic [3:0]         ch_q, ch_d;
   logic [ADC_W-1:0]   data_q, data_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic               convst_q;

   logic [15:0]        mask_eff;
   logic [3:0]         lo_idx, up_idx, hi_idx, pick;
   logic               lo_fnd, up_fnd;

   // Lowest enabled index, lowest enabled index above the current one, and highest enabled index.
   always_comb begin
      mask_eff = ch_mask & VALID_MASK;
      lo_idx   = '0;
      up_idx   = '0;
      hi_idx   = '0;
      lo_fnd   = 1'b0;
      up_fnd   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (mask_eff[i]) begin
            if (!lo_fnd) begin
               lo_idx = 4'(i);
               lo_fnd = 1'b1;
            end
            if (!up_fnd && (i > int'(sel_q))) begin
               up_idx = 4'(i);
               up_fnd = 1'b1;
            end
            hi_idx = 4'(i);
         end
      end
      pick = (first_q || !up_fnd) ? lo_idx : up_idx;
   end

`ifdef EXT_MUX_TIMEOUT_EN
   logic tmo_q, tmo_d;
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      ch_d    = ch_q;
      data_d  = data_q;
      first_d = first_q;
      last_d  = last_q;
`ifdef EXT_MUX_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            first_d = 1'b1;
            if (enable && (mask_eff != '0)) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (mask_eff == '0) begin
               state_d = S_IDLE;
            end else begin
               sel_d   = pick;
               last_d  = (pick == hi_idx);
               first_d = 1'b0;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_CONVST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CONVST: begin
            cnt_d   = '0;
            state_d = S_WAIT_EOC;
         end
         S_WAIT_EOC: begin
            if (adc_eoc) begin
               data_d  = adc_data;
               ch_d    = sel_q;
               state_d = S_OUTPUT;
            end
`ifdef EXT_MUX_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               data_d  = '0;
               ch_d    = sel_q;
               tmo_d   = 1'b1;
               state_d = S_OUTPUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_OUTPUT: begin
            if (smp_ready) state_d = enable ? S_SELECT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         ch_q     <= '0;
         data_q   <= '0;
         first_q  <= 1'b1;
         last_q   <= 1'b0;
         convst_q <= 1'b0;
`ifdef EXT_MUX_TIMEOUT_EN
         tmo_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         ch_q     <= ch_d;
         data_q   <= data_d;
         first_q  <= first_d;
         last_q   <= last_d;
         // Registered pin drive: pulse trails the CONVST state by one cycle, SETTLE_CYCLES+1 after gpio_sel moves.
         convst_q <= (state_q == S_CONVST);
`ifdef EXT_MUX_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign gpio_sel   = sel_q;
   assign adc_convst = convst_q;
   assign smp_valid  = (state_q == S_OUTPUT);
   assign smp_ch     = ch_q;
   assign smp_data   = data_q;
   assign scan_done  = smp_valid && smp_ready && last_q;
   assign busy       = (state_q != S_IDLE);

endmodule
